// File: rtl/uart_pkg.sv
// Shared types and encodings for the UART transmit path.
// Holds the FSM state encoding, parity codes and the latched per-frame configuration.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    typedef struct packed {
        logic       par_en;
        logic       par_bit;
        logic [2:0] last_bit;
        logic       stop2;
    } frame_cfg_t;

    // 00..11 selects 5..8 data bits
    function automatic logic [3:0] data_bits(input logic [1:0] code);
        return 4'd5 + {2'b00, code};
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with a fall-through head (dout valid whenever !empty); count is registered.
// Pushes while full and pops while empty are dropped, so callers may gate loosely.
module uart_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge sys_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW+1)'(1);
            end else if (!do_push && do_pop) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_frame_gen.sv
// UART transmitter: byte FIFO feeding a 5-8 data bit, optional parity, 1/2 stop bit framer.
// Line falls 2 cycles after a write into an idle block; tx_ready drops only while the FIFO is full.
module uart_tx_frame_gen
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4,
    parameter int DIV_W      = 16,
    parameter int MIN_DIV    = 4
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [DIV_W-1:0]   cfg_div,
    input  logic [1:0]         cfg_data_bits,
    input  logic [1:0]         cfg_parity,
    input  logic               cfg_stop2,
    input  logic [7:0]         tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic               tx_busy,
    output logic               tx_done,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               uart_tx
);
    state_t           state;
    frame_cfg_t       fcfg_q;
    frame_cfg_t       fcfg_d;
    logic [DIV_W-1:0] period_q;
    logic [DIV_W-1:0] period_d;
    logic [DIV_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic             stop_cnt;
    logic [7:0]       shift_q;
    logic [7:0]       masked;
    logic [7:0]       fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic             baud_end;
    logic             stop_last;
    logic             line_bit;

    uart_sync_fifo #(
        .DATA_W (8),
        .DEPTH  (FIFO_DEPTH),
        .AW     (FIFO_AW)
    ) u_fifo (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .din       (tx_data),
        .dout      (fifo_dout),
        .count     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign tx_ready  = !fifo_full;
    assign fifo_push = tx_valid && tx_ready;
    assign baud_end  = (baud_cnt == period_q - DIV_W'(1));
    assign stop_last = (stop_cnt == fcfg_q.stop2);
    // Popping at the last stop cycle lets the next start bit follow with no idle gap.
    assign fifo_pop  = !fifo_empty &&
                       ((state == ST_IDLE) || ((state == ST_STOP) && baud_end && stop_last));
    assign period_d  = (cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_div;

    always_comb begin
        masked          = fifo_dout & (8'hFF >> (4'd8 - data_bits(cfg_data_bits)));
        fcfg_d.par_en   = (cfg_parity == PAR_ODD) || (cfg_parity == PAR_EVEN);
        fcfg_d.par_bit  = (cfg_parity == PAR_ODD) ? ~^masked : ^masked;
        fcfg_d.last_bit = 3'(data_bits(cfg_data_bits) - 4'd1);
        fcfg_d.stop2    = cfg_stop2;
    end

    always_comb begin
        line_bit = 1'b1;
        case (state)
            ST_START:  line_bit = 1'b0;
            ST_DATA:   line_bit = shift_q[0];
            ST_PARITY: line_bit = fcfg_q.par_bit;
            default:   line_bit = 1'b1;
        endcase
    end

    // Outputs are registered from the current state, so they trail it by one cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= ST_IDLE;
            fcfg_q   <= '0;
            period_q <= DIV_W'(MIN_DIV);
            baud_cnt <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shift_q  <= '0;
            uart_tx  <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            uart_tx  <= line_bit;
            tx_busy  <= (state != ST_IDLE);
            tx_done  <= (state == ST_STOP) && baud_end && stop_last;
            baud_cnt <= ((state == ST_IDLE) || baud_end) ? '0 : baud_cnt + DIV_W'(1);
            case (state)
                ST_IDLE: state <= ST_IDLE;
                ST_START: begin
                    if (baud_end) begin
                        state   <= ST_DATA;
                        bit_cnt <= '0;
                    end
                end
                ST_DATA: begin
                    if (baud_end) begin
                        shift_q <= shift_q >> 1;
                        if (bit_cnt == fcfg_q.last_bit) begin
                            state    <= fcfg_q.par_en ? ST_PARITY : ST_STOP;
                            stop_cnt <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (baud_end) begin
                        state    <= ST_STOP;
                        stop_cnt <= 1'b0;
                    end
                end
                ST_STOP: begin
                    if (baud_end) begin
                        if (stop_last) begin
                            state <= ST_IDLE;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (fifo_pop) begin
                state    <= ST_START;
                shift_q  <= masked;
                fcfg_q   <= fcfg_d;
                period_q <= period_d;
                baud_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Directed bench: stimulus queues hand-computed line waveforms, a monitor decodes uart_tx against them.
module tb_uart_tx_frame_gen;

    typedef struct {
        int          period;
        int          nbits;
        logic [11:0] bits;
    } exp_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [15:0] cfg_div = 16'd10;
    logic [1:0]  cfg_data_bits = 2'b11;
    logic [1:0]  cfg_parity = 2'b00;
    logic        cfg_stop2 = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic        tx_busy;
    logic        tx_done;
    logic [4:0]  fifo_level;
    logic        uart_tx;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    bit   mon_en = 1'b0;
    bit   mon_busy = 1'b0;

    uart_tx_frame_gen dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .cfg_div       (cfg_div),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done),
        .fifo_level    (fifo_level),
        .uart_tx       (uart_tx)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input bit track, input int period,
                        input int nbits, input logic [11:0] bits);
        int guard = 0;
        @(negedge sys_clk);
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && guard < 5000) begin
            @(negedge sys_clk);
            guard++;
        end
        chk("send_ready", tx_ready, 1);
        if (track) exp_q.push_back('{period, nbits, bits});
        @(posedge sys_clk);
        #1;
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || mon_busy || tx_busy || fifo_level != 0) && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        chk({name, "_drain"}, int'(n < budget), 1);
    endtask

    // Monitor: every frame on the line must match the oldest queued waveform cycle by cycle.
    initial begin : monitor
        exp_t e;
        int   mism;
        int   busy_bad;
        int   done_bad;
        int   frame_no;
        frame_no = 0;
        forever begin
            @(negedge sys_clk);
            if (mon_en && sys_rst_n && uart_tx == 1'b0) begin
                mon_busy = 1'b1;
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                    for (int k = 0; k < 5000 && !(uart_tx && !tx_busy); k++) @(negedge sys_clk);
                end else begin
                    e        = exp_q.pop_front();
                    busy_bad = 0;
                    done_bad = 0;
                    for (int b = 0; b < e.nbits; b++) begin
                        mism = 0;
                        for (int c = 0; c < e.period; c++) begin
                            if (b != 0 || c != 0) @(negedge sys_clk);
                            if (uart_tx !== e.bits[b]) mism++;
                            if (tx_busy !== 1'b1) busy_bad++;
                            if (tx_done !== ((b == e.nbits - 1) && (c == e.period - 1))) done_bad++;
                        end
                        chk($sformatf("frame%0d_bit%0d_bad_cycles", frame_no, b), mism, 0);
                    end
                    chk($sformatf("frame%0d_busy_bad_cycles", frame_no), busy_bad, 0);
                    chk($sformatf("frame%0d_done_bad_cycles", frame_no), done_bad, 0);
                    frame_no++;
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int fall;
        int done_c;
        int busy_off;
        int acc;
        int n;
        int ready_early;
        int done_cnt;
        int bad;

        repeat (3) @(negedge sys_clk);
        chk("rst_uart_tx", uart_tx, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ready", tx_ready, 1);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        mon_en = 1'b1;

        // 8N1, div 10, 0x55 from idle
        cfg_div = 16'd10; cfg_data_bits = 2'b11; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        send(8'h55, 1'b1, 10, 10, 12'h2AA);
        fall = -1; done_c = -1; busy_off = -1;
        for (int k = 0; k < 120; k++) begin
            @(negedge sys_clk);
            if (fall < 0 && !uart_tx) fall = k;
            if (done_c < 0 && tx_done) done_c = k;
            if (busy_off < 0 && done_c >= 0 && !tx_busy) busy_off = k;
        end
        chk("8n1_start_latency", fall, 2);
        chk("8n1_done_cycle", done_c, 101);
        chk("8n1_busy_fall", busy_off, 102);
        wait_idle("8n1", 500);

        // 7O1, div 8, 0xC1: bit 7 dropped, odd parity 1
        cfg_div = 16'd8; cfg_data_bits = 2'b10; cfg_parity = 2'b01; cfg_stop2 = 1'b0;
        send(8'hC1, 1'b1, 8, 10, 12'h382);
        wait_idle("7o1", 500);

        // 5E2, div 2 clamped to 4, 0x1F
        cfg_div = 16'd2; cfg_data_bits = 2'b00; cfg_parity = 2'b10; cfg_stop2 = 1'b1;
        send(8'h1F, 1'b1, 4, 9, 12'h1FE);
        wait_idle("5e2", 500);

        // FIFO fill with tx_valid held high from idle
        cfg_div = 16'd4; cfg_data_bits = 2'b11; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        @(negedge sys_clk);
        tx_valid = 1'b1;
        acc = 0; n = 0;
        while (acc < 17 && n < 40) begin
            tx_data = 8'h30 + 8'(acc);
            if (tx_ready) begin
                exp_q.push_back('{4, 10, 12'h200 | {3'b000, tx_data, 1'b0}});
                acc++;
            end
            @(posedge sys_clk);
            #1;
            if (acc == 17) tx_valid = 1'b0;
            @(negedge sys_clk);
            n++;
        end
        tx_valid = 1'b0;
        chk("fill_accepts", acc, 17);
        chk("fill_cycles", n, 17);
        chk("fill_ready_low", tx_ready, 0);
        chk("fill_level", fifo_level, 16);
        ready_early = 0; n = 0;
        while (!tx_done && n < 200) begin
            if (tx_ready) ready_early++;
            @(negedge sys_clk);
            n++;
        end
        chk("fill_first_done_seen", tx_done, 1);
        chk("fill_ready_before_done", ready_early, 0);
        done_cnt = 1;
        @(negedge sys_clk);
        chk("fill_ready_after_done", tx_ready, 1);
        n = 0;
        while (tx_busy && n < 2000) begin
            if (tx_done) done_cnt++;
            @(negedge sys_clk);
            n++;
        end
        chk("fill_done_pulses", done_cnt, 17);
        wait_idle("fill", 500);

        // Config change mid-frame: 8N1 frame completes, queued byte goes out as 6E1
        cfg_div = 16'd6; cfg_data_bits = 2'b11; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        send(8'hA5, 1'b1, 6, 10, 12'h34A);
        send(8'hBC, 1'b1, 6, 9, 12'h178);
        cfg_data_bits = 2'b01; cfg_parity = 2'b10;
        wait_idle("cfgchg", 500);

        // Reset asserted mid-DATA of the second queued byte
        mon_en = 1'b0;
        cfg_div = 16'd4; cfg_data_bits = 2'b11; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        send(8'h11, 1'b0, 0, 0, 12'h000);
        send(8'h22, 1'b0, 0, 0, 12'h000);
        send(8'h33, 1'b0, 0, 0, 12'h000);
        n = 0;
        while (!tx_done && n < 500) begin
            @(negedge sys_clk);
            n++;
        end
        chk("rst_first_done_seen", tx_done, 1);
        repeat (12) @(negedge sys_clk);
        chk("rst_pre_busy", tx_busy, 1);
        chk("rst_pre_level", fifo_level, 1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("midrst_uart_tx", uart_tx, 1);
        chk("midrst_level", fifo_level, 0);
        chk("midrst_ready", tx_ready, 1);
        chk("midrst_busy", tx_busy, 0);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge sys_clk);
            if (!uart_tx || tx_busy || tx_done) bad++;
        end
        chk("postrst_activity_cycles", bad, 0);
        chk("postrst_level", fifo_level, 0);
        chk("unconsumed_frames", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
